// File: rtl/deskew_pkg.sv
// Shared types and default constants for the MMCM phase-deskew controller.
package deskew_pkg;

  // Per-channel controller states.
  typedef enum logic [2:0] {
    StRstHold,
    StWaitLock,
    StIdle,
    StStep,
    StWaitDone
  } deskew_state_e;

  localparam int unsigned DefNumCh        = 2;
  localparam int unsigned DefPhaseW       = 10;
  localparam int unsigned DefRstHoldCyc   = 16;
  localparam int unsigned DefLockTimeout  = 65535;
  localparam int unsigned DefDoneTimeout  = 64;
  localparam int unsigned LossCntW        = 8;

  // Largest of three cycle counts; sizes the shared per-channel counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/deskew_chan_fsm.sv
// One MMCM deskew channel: reset/lock sequencing and single-step phase walking.
// Optional lock-loss counter output when DESKEW_LOSS_COUNT_EN is defined.
module deskew_chan_fsm
  import deskew_pkg::*;
#(
  parameter int unsigned PHASE_W      = DefPhaseW,
  parameter int unsigned RST_HOLD_CYC = DefRstHoldCyc,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned DONE_TIMEOUT = DefDoneTimeout
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [PHASE_W-1:0] target_phase_i,
  input  logic                      target_valid_i,
  output logic                      target_ready_o,
  input  logic                      mmcm_locked_i,
  output logic                      mmcm_rst_o,
  output logic                      ps_en_o,
  output logic                      ps_incdec_o,
  input  logic                      ps_done_i,
  output logic signed [PHASE_W-1:0] cur_phase_o,
  output logic                      busy_o,
  output logic                      locked_o
`ifdef DESKEW_LOSS_COUNT_EN
  ,
  output logic [LossCntW-1:0]       lock_loss_cnt_o
`endif
);

  localparam int unsigned CntMax = max3(RST_HOLD_CYC, LOCK_TIMEOUT, DONE_TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  deskew_state_e             state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic signed [PHASE_W-1:0] cur_q, cur_d;
  logic signed [PHASE_W-1:0] tgt_q, tgt_d;
  logic                      incdec_q, incdec_d;
  logic                      lock_meta_q, lock_meta_d;
  logic                      lock_sync_q, lock_sync_d;
  logic                      step_up;

`ifdef DESKEW_LOSS_COUNT_EN
  logic [LossCntW-1:0]       loss_q, loss_d;
`endif

  // State and datapath registers; rst forces RST_HOLD with everything cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRstHold;
      cnt_q       <= '0;
      cur_q       <= '0;
      tgt_q       <= '0;
      incdec_q    <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
`ifdef DESKEW_LOSS_COUNT_EN
      loss_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      incdec_q    <= incdec_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
`ifdef DESKEW_LOSS_COUNT_EN
      loss_q      <= loss_d;
`endif
    end
  end

  // Next-state logic: lock loss dominates every other event once the MMCM is up.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    incdec_d    = incdec_q;
    lock_meta_d = mmcm_locked_i;
    lock_sync_d = lock_meta_q;
    step_up     = (tgt_q > cur_q);

    unique case (state_q)
      StRstHold: begin
        cur_d = '0;
        if (cnt_q == CntW'(RST_HOLD_CYC - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StWaitLock: begin
        if (lock_sync_q) begin
          cnt_d   = '0;
          state_d = (cur_q == tgt_q) ? StIdle : StStep;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          state_d = StRstHold;
          cnt_d   = '0;
          cur_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StIdle: begin
        // Ready is unconditional here, so a request in the lock-loss cycle is still kept.
        if (target_valid_i) tgt_d = target_phase_i;
        if (!lock_sync_q) begin
          state_d = StRstHold;
          cnt_d   = '0;
          cur_d   = '0;
        end else if (target_valid_i && (target_phase_i != cur_q)) begin
          state_d = StStep;
        end
      end

      StStep: begin
        incdec_d = step_up;
        cnt_d    = '0;
        if (!lock_sync_q) begin
          state_d = StRstHold;
          cur_d   = '0;
        end else begin
          state_d = StWaitDone;
        end
      end

      StWaitDone: begin
        if (!lock_sync_q) begin
          state_d = StRstHold;
          cnt_d   = '0;
          cur_d   = '0;
        end else if (ps_done_i) begin
          cur_d   = incdec_q ? (cur_q + PHASE_W'(1)) : (cur_q - PHASE_W'(1));
          cnt_d   = '0;
          state_d = (cur_d != tgt_q) ? StStep : StIdle;
        end else if (cnt_q == CntW'(DONE_TIMEOUT - 1)) begin
          state_d = StRstHold;
          cnt_d   = '0;
          cur_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StRstHold;
        cnt_d   = '0;
        cur_d   = '0;
      end
    endcase
  end

`ifdef DESKEW_LOSS_COUNT_EN
  // Count every non-rst entry into RST_HOLD, saturating at all-ones.
  always_comb begin
    loss_d = loss_q;
    if ((state_d == StRstHold) && (state_q != StRstHold) && (loss_q != '1)) begin
      loss_d = loss_q + LossCntW'(1);
    end
  end

  assign lock_loss_cnt_o = loss_q;
`endif

  // Moore outputs; PSINCDEC is held through WAIT_DONE from the value captured in STEP.
  always_comb begin
    mmcm_rst_o     = (state_q == StRstHold);
    ps_en_o        = (state_q == StStep);
    ps_incdec_o    = 1'b0;
    if (state_q == StStep)     ps_incdec_o = step_up;
    if (state_q == StWaitDone) ps_incdec_o = incdec_q;
    target_ready_o = (state_q == StIdle);
    busy_o         = (state_q != StIdle);
    locked_o       = (state_q == StIdle) && lock_sync_q;
    cur_phase_o    = cur_q;
  end

endmodule

// File: rtl/clock_deskew_phase_ctrl.sv
// Multi-channel MMCM phase-deskew controller: NUM_CH independent channel FSMs.
// Define DESKEW_LOSS_COUNT_EN to add the per-channel lock_loss_cnt output.
module clock_deskew_phase_ctrl
  import deskew_pkg::*;
#(
  parameter int unsigned NUM_CH       = DefNumCh,
  parameter int unsigned PHASE_W      = DefPhaseW,
  parameter int unsigned RST_HOLD_CYC = DefRstHoldCyc,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned DONE_TIMEOUT = DefDoneTimeout
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*PHASE_W-1:0]   target_phase,
  input  logic [NUM_CH-1:0]           target_valid,
  output logic [NUM_CH-1:0]           target_ready,
  input  logic [NUM_CH-1:0]           mmcm_locked,
  output logic [NUM_CH-1:0]           mmcm_rst,
  output logic [NUM_CH-1:0]           ps_en,
  output logic [NUM_CH-1:0]           ps_incdec,
  input  logic [NUM_CH-1:0]           ps_done,
  output logic [NUM_CH*PHASE_W-1:0]   cur_phase,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           locked
`ifdef DESKEW_LOSS_COUNT_EN
  ,
  output logic [NUM_CH*LossCntW-1:0]  lock_loss_cnt
`endif
);

  // One self-contained FSM per channel; the buses are plain concatenations.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    deskew_chan_fsm #(
      .PHASE_W      (PHASE_W),
      .RST_HOLD_CYC (RST_HOLD_CYC),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .target_phase_i (target_phase[g*PHASE_W +: PHASE_W]),
      .target_valid_i (target_valid[g]),
      .target_ready_o (target_ready[g]),
      .mmcm_locked_i  (mmcm_locked[g]),
      .mmcm_rst_o     (mmcm_rst[g]),
      .ps_en_o        (ps_en[g]),
      .ps_incdec_o    (ps_incdec[g]),
      .ps_done_i      (ps_done[g]),
      .cur_phase_o    (cur_phase[g*PHASE_W +: PHASE_W]),
      .busy_o         (busy[g]),
      .locked_o       (locked[g])
`ifdef DESKEW_LOSS_COUNT_EN
      ,
      .lock_loss_cnt_o (lock_loss_cnt[g*LossCntW +: LossCntW])
`endif
    );
  end

endmodule
